prod_accum: RTL and testbench

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/prod_accum.sv | 176 +++++++++++++++++
 tb/tb_prod_accum.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/prod_accum.sv
// Block accumulator for a fixed-latency multiplier stream: sums `len` products per block,
// detecting each product on a rising edge of `valid`, and publishes the exact and 64-bit saturated sums.
module prod_accum #(
    parameter int LEN_W = 8,
    parameter int ACC_W = 72
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [63:0]        prodt,
    input  logic               valid,
    input  logic [LEN_W-1:0]   len,
    input  logic               clear,
    output logic [ACC_W-1:0]   acc_out,
    output logic [63:0]        sat_out,
    output logic               ovf,
    output logic               acc_valid,
    output logic               busy,
    output logic [LEN_W:0]     cnt
);

    localparam int CW = LEN_W + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_valid_q;
    logic               w_rise;
    logic [CW-1:0]      r_len;
    logic [CW-1:0]      w_len_nxt;
    logic [CW-1:0]      w_len_eff;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [CW-1:0]      w_cnt_inc;

    logic [ACC_W-1:0]   r_acc_out;
    logic [63:0]        r_sat_out;
    logic               r_ovf;
    logic               r_acc_valid;
    logic               r_busy;
    logic [ACC_W-1:0]   w_acc_out_nxt;
    logic [63:0]        w_sat_out_nxt;
    logic               w_ovf_nxt;
    logic               w_acc_valid_nxt;
    logic               w_busy_nxt;

    // True when the bits above bit 62 are all copies of the sign, i.e. the value fits in 64 signed bits.
    function automatic logic fits64(input logic [ACC_W-1:0] a);
        logic [ACC_W-64:0] top;
        top = a[ACC_W-1:63];
        return (top == {(ACC_W-63){1'b0}}) || (top == {(ACC_W-63){1'b1}});
    endfunction

    function automatic logic [63:0] sat64(input logic [ACC_W-1:0] a);
        logic [63:0] res;
        if (fits64(a)) begin
            res = a[63:0];
        end else if (a[ACC_W-1]) begin
            res = 64'h8000_0000_0000_0000;
        end else begin
            res = 64'h7FFF_FFFF_FFFF_FFFF;
        end
        return res;
    endfunction

    assign w_rise     = valid & ~r_valid_q;
    assign w_prod_ext = {{(ACC_W-64){prodt[63]}}, prodt};
    assign w_cnt_inc  = r_cnt + CNT_ONE;
    // A zero length encodes the full 2^LEN_W block.
    assign w_len_eff  = (len == {LEN_W{1'b0}}) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};

    // State and datapath registers; valid_q resets high so a level already present is not a rise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_valid_q <= 1'b1;
            r_len     <= CNT_ZERO;
            r_acc     <= {ACC_W{1'b0}};
            r_cnt     <= CNT_ZERO;
        end else begin
            r_state   <= w_state_nxt;
            r_valid_q <= valid;
            r_len     <= w_len_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Next-state and accumulator update; clear overrides any rise seen in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = CNT_ZERO;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_rise) begin
                        w_len_nxt   = w_len_eff;
                        w_acc_nxt   = w_prod_ext;
                        w_cnt_nxt   = CNT_ONE;
                        w_state_nxt = (w_len_eff == CNT_ONE) ? S_DONE : S_ACCUM;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = CNT_ZERO;
                    end
                end
                S_ACCUM: begin
                    if (w_rise) begin
                        w_acc_nxt   = r_acc + w_prod_ext;
                        w_cnt_nxt   = w_cnt_inc;
                        w_state_nxt = (w_cnt_inc == r_len) ? S_DONE : S_ACCUM;
                    end else begin
                        w_state_nxt = S_ACCUM;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output values for the coming cycle; results only change on entry to DONE.
    always_comb begin
        w_acc_valid_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt      = (w_state_nxt == S_ACCUM);
        if (w_acc_valid_nxt) begin
            w_acc_out_nxt = w_acc_nxt;
            w_sat_out_nxt = sat64(w_acc_nxt);
            w_ovf_nxt     = ~fits64(w_acc_nxt);
        end else begin
            w_acc_out_nxt = r_acc_out;
            w_sat_out_nxt = r_sat_out;
            w_ovf_nxt     = r_ovf;
        end
    end

    // Registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc_out   <= {ACC_W{1'b0}};
            r_sat_out   <= 64'h0;
            r_ovf       <= 1'b0;
            r_acc_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_acc_out   <= w_acc_out_nxt;
            r_sat_out   <= w_sat_out_nxt;
            r_ovf       <= w_ovf_nxt;
            r_acc_valid <= w_acc_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign acc_out   = r_acc_out;
    assign sat_out   = r_sat_out;
    assign ovf       = r_ovf;
    assign acc_valid = r_acc_valid;
    assign busy      = r_busy;
    assign cnt       = r_cnt;

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: a block-level reference model checked every cycle, plus directed
// scenarios with hand-computed block results.
module tb_prod_accum;

    localparam int LEN_W = 8;
    localparam int ACC_W = 72;
    localparam logic signed [71:0] MAXV = 72'sh00_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [71:0] MINV = 72'shFF_8000_0000_0000_0000;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             valid = 1'b0;
    logic             clear = 1'b0;
    logic [63:0]      prodt = 64'h0;
    logic [LEN_W-1:0] len   = 8'd0;

    logic [ACC_W-1:0] acc_out;
    logic [63:0]      sat_out;
    logic             ovf;
    logic             acc_valid;
    logic             busy;
    logic [LEN_W:0]   cnt;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0 = 0;
    logic [71:0] last_acc = 72'h0;
    logic [63:0] last_sat = 64'h0;
    logic        last_ovf = 1'b0;

    prod_accum #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clock(clock), .reset(reset), .prodt(prodt), .valid(valid), .len(len), .clear(clear),
        .acc_out(acc_out), .sat_out(sat_out), .ovf(ovf), .acc_valid(acc_valid),
        .busy(busy), .cnt(cnt)
    );

    always #5 clock = ~clock;

    // Reference model: counts products of the open block and emits the block sum when it is full.
    logic               m_vq;
    int                 m_n;
    int                 m_len;
    logic signed [71:0] m_sum;
    logic [71:0]        e_acc_out;
    logic [63:0]        e_sat;
    logic               e_ovf;
    logic               e_valid;
    logic               e_busy;
    logic [8:0]         e_cnt;

    logic               m_rise;
    int                 m_leff;
    int                 m_nn;
    logic signed [71:0] m_ext;
    logic signed [71:0] m_sum_n;

    function automatic logic [63:0] clamp(input logic signed [71:0] s);
        if (s > MAXV) return 64'h7FFF_FFFF_FFFF_FFFF;
        else if (s < MINV) return 64'h8000_0000_0000_0000;
        else return s[63:0];
    endfunction

    assign m_rise  = valid && !m_vq;
    assign m_leff  = (m_n == 0) ? ((len == 8'd0) ? 256 : int'(len)) : m_len;
    assign m_nn    = (m_n == 0) ? 1 : m_n + 1;
    assign m_ext   = {{8{prodt[63]}}, prodt};
    assign m_sum_n = (m_n == 0) ? m_ext : m_sum + m_ext;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_vq <= 1'b1; m_n <= 0; m_len <= 0; m_sum <= 72'sh0;
            e_acc_out <= 72'h0; e_sat <= 64'h0; e_ovf <= 1'b0;
            e_valid <= 1'b0; e_busy <= 1'b0; e_cnt <= 9'd0;
        end else begin
            m_vq    <= valid;
            e_valid <= 1'b0;
            if (clear) begin
                m_n <= 0; e_cnt <= 9'd0; e_busy <= 1'b0;
            end else if (m_rise) begin
                m_len <= m_leff;
                m_sum <= m_sum_n;
                e_cnt <= 9'(m_nn);
                if (m_nn == m_leff) begin
                    m_n <= 0; e_valid <= 1'b1; e_busy <= 1'b0;
                    e_acc_out <= m_sum_n;
                    e_sat <= clamp(m_sum_n);
                    e_ovf <= (m_sum_n > MAXV) || (m_sum_n < MINV);
                end else begin
                    m_n <= m_nn; e_busy <= 1'b1;
                end
            end else begin
                e_cnt  <= 9'(m_n);
                e_busy <= (m_n != 0);
            end
        end
    end

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance to the falling edge, compare every output with the model, record result pulses.
    task automatic tick();
        @(negedge clock);
        chk("acc_valid", 72'(acc_valid), 72'(e_valid));
        chk("busy",      72'(busy),      72'(e_busy));
        chk("cnt",       72'(cnt),       72'(e_cnt));
        chk("acc_out",   acc_out,        e_acc_out);
        chk("sat_out",   72'(sat_out),   72'(e_sat));
        chk("ovf",       72'(ovf),       72'(e_ovf));
        if (acc_valid === 1'b1) begin
            pulses++;
            last_acc = acc_out;
            last_sat = sat_out;
            last_ovf = ovf;
        end
    endtask

    task automatic pulse(input logic [63:0] p);
        prodt = p; valid = 1'b1; tick();
        valid = 1'b0; tick();
    endtask

    initial begin
        tick(); tick();
        chk("rst_acc_out", acc_out, 72'h0);
        chk("rst_cnt", 72'(cnt), 72'h0);
        chk("rst_busy", 72'(busy), 72'h0);
        chk("rst_valid", 72'(acc_valid), 72'h0);
        reset = 1'b0; tick();

        // 5 - 7 + 100, with a len change mid-block that must be ignored
        len = 8'd3; p0 = pulses;
        pulse(64'd5); len = 8'd7;
        pulse(-64'sd7); pulse(64'd100); tick();
        chk("t3_pulses", 72'(pulses - p0), 72'd1);
        chk("t3_acc", last_acc, 72'd98);
        chk("t3_sat", 72'(last_sat), 72'd98);
        chk("t3_ovf", 72'(last_ovf), 72'd0);

        // held-high valid counts once
        len = 8'd1; p0 = pulses; prodt = 64'd42; valid = 1'b1;
        repeat (10) tick();
        valid = 1'b0; tick();
        chk("held_pulses", 72'(pulses - p0), 72'd1);
        chk("held_acc", last_acc, 72'd42);

        // 2^62 + 2^62 saturates positive
        len = 8'd2;
        pulse(64'h4000_0000_0000_0000); pulse(64'h4000_0000_0000_0000); tick();
        chk("pos_acc", last_acc, 72'h00_8000_0000_0000_0000);
        chk("pos_sat", 72'(last_sat), 72'h7FFF_FFFF_FFFF_FFFF);
        chk("pos_ovf", 72'(last_ovf), 72'd1);

        // clear after two products, with a simultaneous rise that must be dropped
        len = 8'd4; p0 = pulses;
        pulse(64'd11); pulse(64'd22);
        clear = 1'b1; prodt = 64'd99; valid = 1'b1; tick();
        clear = 1'b0; valid = 1'b0;
        chk("clr_cnt", 72'(cnt), 72'd0);
        chk("clr_busy", 72'(busy), 72'd0);
        chk("clr_hold", acc_out, 72'h00_8000_0000_0000_0000);
        tick();
        pulse(64'd1); pulse(64'd2); pulse(64'd3); pulse(64'd4); tick();
        chk("clr_pulses", 72'(pulses - p0), 72'd1);
        chk("clr_acc", last_acc, 72'd10);

        // back-to-back blocks at full rate
        len = 8'd2; p0 = pulses;
        pulse(64'd10); pulse(64'd20);
        chk("b2b_a", last_acc, 72'd30);
        pulse(64'd30); pulse(64'd40); tick();
        chk("b2b_pulses", 72'(pulses - p0), 72'd2);
        chk("b2b_b", last_acc, 72'd70);

        // -2^63 exactly is representable; -2^63 - 1 saturates negative
        len = 8'd1;
        pulse(64'h8000_0000_0000_0000); tick();
        chk("min_ovf", 72'(last_ovf), 72'd0);
        chk("min_sat", 72'(last_sat), 72'h8000_0000_0000_0000);
        len = 8'd2;
        pulse(64'h8000_0000_0000_0000); pulse(64'hFFFF_FFFF_FFFF_FFFF); tick();
        chk("neg_acc", last_acc, 72'hFF_7FFF_FFFF_FFFF_FFFF);
        chk("neg_sat", 72'(last_sat), 72'h8000_0000_0000_0000);
        chk("neg_ovf", 72'(last_ovf), 72'd1);

        // len=0: 256 products of -2^63 fill the guard bits exactly
        len = 8'd0; p0 = pulses;
        repeat (256) pulse(64'h8000_0000_0000_0000);
        tick();
        chk("full_pulses", 72'(pulses - p0), 72'd1);
        chk("full_acc", last_acc, 72'h80_0000_0000_0000_0000);
        chk("full_ovf", 72'(last_ovf), 72'd1);

        // reset mid-block with valid held high through release
        len = 8'd4; p0 = pulses;
        pulse(64'd1); pulse(64'd2);
        prodt = 64'd3; valid = 1'b1; tick();
        reset = 1'b1; tick(); tick();
        reset = 1'b0; tick(); tick(); tick();
        chk("rstm_cnt", 72'(cnt), 72'd0);
        chk("rstm_acc", acc_out, 72'h0);
        chk("rstm_busy", 72'(busy), 72'd0);
        valid = 1'b0; tick();
        len = 8'd1;
        pulse(64'd7); tick();
        chk("rstm_pulses", 72'(pulses - p0), 72'd1);
        chk("rstm_acc2", last_acc, 72'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
